carwash_ctrl: RTL and testbench

//  Parametrised car wash controller. Successor to the fixed single-program FSM.

---
 rtl/carwash_pkg.sv | 29 ++
 rtl/cw_phase_timer.sv | 27 ++
 rtl/carwash_ctrl.sv | 142 ++++++++++++++
 tb/tb_carwash_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/carwash_pkg.sv
// Shared types for the car wash controller: FSM states, wash programs and
// the credit-to-program mapping.
package carwash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CREDIT,
    PRESPRAY,
    SOAP,
    RINSE,
    WAX,
    DONE
  } cw_state_t;

  typedef enum logic [1:0] {
    BASIC   = 2'd1,
    DELUXE  = 2'd2,
    PREMIUM = 2'd3
  } cw_mode_t;

  function automatic cw_mode_t credits_to_mode(input logic [1:0] credits);
    case (credits)
      2'd2:    return DELUXE;
      2'd3:    return PREMIUM;
      default: return BASIC;
    endcase
  endfunction

endpackage

// File: rtl/cw_phase_timer.sv
// Up-counter shared by every wash phase and the CREDIT idle timeout.
// expired is high while the count equals limit; the count saturates at all-ones.
module cw_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               restart,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/carwash_ctrl.sv
// Car wash controller: token credit, program select, timed spray/soap/rinse/wax
// phases, idle auto-start and abort. All outputs are registered Moore decodes.
module carwash_ctrl #(
  parameter int MAX_TOKENS = 3,
  parameter int TIMER_W    = 16,
  parameter int SPRAY_CYC  = 100,
  parameter int SOAP_CYC   = 200,
  parameter int RINSE_CYC  = 150,
  parameter int WAX_CYC    = 120,
  parameter int IDLE_CYC   = 1000
) (
  input  logic                                clk,
  input  logic                                clr_n,
  input  logic                                TOKEN,
  input  logic                                START,
  input  logic                                ABORT,
  output logic                                SPRAY,
  output logic                                SOAP,
  output logic                                WAX,
  output logic                                BUSY,
  output logic                                DONE,
  output logic                                TOKEN_REJ,
  output logic [$clog2(MAX_TOKENS+1)-1:0]     CREDITS
);
  import carwash_pkg::*;

  localparam int                 CRED_W   = $clog2(MAX_TOKENS + 1);
  localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(MAX_TOKENS);

  // State literals are package-qualified because SOAP, WAX and DONE are also port names.
  cw_state_t          state, state_nxt;
  cw_mode_t           mode, mode_nxt;
  logic [CRED_W-1:0]  cred_nxt, cred_inc;
  logic [TIMER_W-1:0] limit;
  logic               token_q, tok_edge, rej_nxt, expired, restart;

  assign tok_edge = TOKEN & ~token_q;
  assign cred_inc = (CREDITS < CRED_MAX) ? CREDITS + CRED_W'(1) : CREDITS;
  assign restart  = (state_nxt != state);

  always_comb begin
    case (state)
      carwash_pkg::CREDIT:   limit = TIMER_W'(IDLE_CYC - 1);
      carwash_pkg::PRESPRAY: limit = TIMER_W'(SPRAY_CYC - 1);
      carwash_pkg::SOAP:     limit = TIMER_W'(SOAP_CYC - 1);
      carwash_pkg::RINSE:    limit = TIMER_W'(RINSE_CYC - 1);
      carwash_pkg::WAX:      limit = TIMER_W'(WAX_CYC - 1);
      default:               limit = '0;
    endcase
  end

  cw_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (restart),
    .limit   (limit),
    .expired (expired)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    mode_nxt  = mode;
    cred_nxt  = CREDITS;
    rej_nxt   = 1'b0;
    if (ABORT) begin
      state_nxt = carwash_pkg::IDLE;
      cred_nxt  = '0;
    end else begin
      case (state)
        carwash_pkg::IDLE: begin
          if (tok_edge) begin
            cred_nxt  = CRED_W'(1);
            state_nxt = carwash_pkg::CREDIT;
          end
        end
        carwash_pkg::CREDIT: begin
          if (tok_edge) begin
            rej_nxt  = (CREDITS == CRED_MAX);
            cred_nxt = cred_inc;
          end
          // A token arriving with START is already in cred_nxt, so it sets the mode.
          if (START || expired) begin
            mode_nxt  = credits_to_mode(2'(cred_nxt));
            cred_nxt  = '0;
            state_nxt = carwash_pkg::PRESPRAY;
          end
        end
        carwash_pkg::PRESPRAY: begin
          rej_nxt = tok_edge;
          if (expired) state_nxt = (mode == BASIC) ? carwash_pkg::DONE : carwash_pkg::SOAP;
        end
        carwash_pkg::SOAP: begin
          rej_nxt = tok_edge;
          if (expired) state_nxt = carwash_pkg::RINSE;
        end
        carwash_pkg::RINSE: begin
          rej_nxt = tok_edge;
          if (expired) state_nxt = (mode == PREMIUM) ? carwash_pkg::WAX : carwash_pkg::DONE;
        end
        carwash_pkg::WAX: begin
          rej_nxt = tok_edge;
          if (expired) state_nxt = carwash_pkg::DONE;
        end
        carwash_pkg::DONE: begin
          rej_nxt   = tok_edge;
          state_nxt = carwash_pkg::IDLE;
        end
        default: state_nxt = carwash_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= carwash_pkg::IDLE;
      mode      <= BASIC;
      CREDITS   <= '0;
      token_q   <= 1'b1;  // a TOKEN already high when reset lifts is not an edge
      SPRAY     <= 1'b0;
      SOAP      <= 1'b0;
      WAX       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      TOKEN_REJ <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state     <= state_nxt;
      mode      <= mode_nxt;
      CREDITS   <= cred_nxt;
      token_q   <= TOKEN;
      SPRAY     <= (state_nxt inside {carwash_pkg::PRESPRAY, carwash_pkg::RINSE});
      SOAP      <= (state_nxt == carwash_pkg::SOAP);
      WAX       <= (state_nxt == carwash_pkg::WAX);
      BUSY      <= (state_nxt inside {carwash_pkg::PRESPRAY, carwash_pkg::SOAP,
                                      carwash_pkg::RINSE, carwash_pkg::WAX});
      DONE      <= (state_nxt == carwash_pkg::DONE);
      TOKEN_REJ <= rej_nxt;
    end
  end

endmodule

// File: tb/tb_carwash_ctrl.sv
// Directed bench for carwash_ctrl with short phase lengths
// (spray 4, soap 5, rinse 3, wax 2, idle timeout 20).
module tb_carwash_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       TOKEN = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       SPRAY, SOAP, WAX, BUSY, DONE, TOKEN_REJ;
  logic [1:0] CREDITS;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Per-run tallies filled in by run_wash.
  int r_spray, r_soap, r_wax, r_busy, r_done, r_rej, r_first_spray, r_done_idx, r_max_cred;
  int rej_seen;

  carwash_ctrl #(
    .MAX_TOKENS(3), .TIMER_W(8), .SPRAY_CYC(4), .SOAP_CYC(5),
    .RINSE_CYC(3), .WAX_CYC(2), .IDLE_CYC(20)
  ) dut (
    .clk(clk), .clr_n(clr_n), .TOKEN(TOKEN), .START(START), .ABORT(ABORT),
    .SPRAY(SPRAY), .SOAP(SOAP), .WAX(WAX), .BUSY(BUSY), .DONE(DONE),
    .TOKEN_REJ(TOKEN_REJ), .CREDITS(CREDITS)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle token pulse followed by one low cycle; counts refusals seen.
  task automatic insert_token();
    TOKEN = 1'b1;
    step();
    if (TOKEN_REJ) rej_seen++;
    TOKEN = 1'b0;
    step();
    if (TOKEN_REJ) rej_seen++;
  endtask

  task automatic press_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Samples n cycles (index 0 = now), optionally pulsing TOKEN at index tok_at.
  task automatic run_wash(input int n, input int tok_at);
    r_spray = 0; r_soap = 0; r_wax = 0; r_busy = 0; r_done = 0; r_rej = 0;
    r_first_spray = -1; r_done_idx = -1; r_max_cred = 0;
    for (int i = 0; i < n; i++) begin
      if (SPRAY) begin
        r_spray++;
        if (r_first_spray < 0) r_first_spray = i;
      end
      if (SOAP) r_soap++;
      if (WAX) r_wax++;
      if (BUSY) r_busy++;
      if (DONE) begin
        r_done++;
        r_done_idx = i;
      end
      if (TOKEN_REJ) r_rej++;
      if (int'(CREDITS) > r_max_cred) r_max_cred = int'(CREDITS);
      TOKEN = (i == tok_at);
      step();
    end
    TOKEN = 1'b0;
  endtask

  task automatic test_reset();
    TOKEN = 1'b1;
    clr_n = 1'b0;
    #1;
    chk_cnt++; if ({SPRAY, SOAP, WAX, BUSY, DONE, TOKEN_REJ} !== 6'b0) $display("FAIL reset_outputs: got %b want 000000", {SPRAY, SOAP, WAX, BUSY, DONE, TOKEN_REJ}); else pass_cnt++;
    chk_cnt++; if (CREDITS !== 2'd0) $display("FAIL reset_credits: got %0d want 0", CREDITS); else pass_cnt++;
    step(); step();
    clr_n = 1'b1;
    rej_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (TOKEN_REJ) rej_seen++;
    end
    chk_cnt++; if (CREDITS !== 2'd0) $display("FAIL token_held_credits: got %0d want 0", CREDITS); else pass_cnt++;
    chk_cnt++; if (rej_seen !== 0) $display("FAIL token_held_rej: got %0d want 0", rej_seen); else pass_cnt++;
    TOKEN = 1'b0;
    step();
    insert_token();
    chk_cnt++; if (CREDITS !== 2'd1) $display("FAIL first_token_credits: got %0d want 1", CREDITS); else pass_cnt++;
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
  endtask

  task automatic test_basic();
    insert_token();
    chk_cnt++; if (CREDITS !== 2'd1) $display("FAIL basic_credits: got %0d want 1", CREDITS); else pass_cnt++;
    START = 1'b1;
    #1;
    chk_cnt++; if (SPRAY !== 1'b0) $display("FAIL basic_start_latency: got %b want 0", SPRAY); else pass_cnt++;
    step();
    START = 1'b0;
    run_wash(30, -1);
    chk_cnt++; if (r_first_spray !== 0) $display("FAIL basic_first_spray: got %0d want 0", r_first_spray); else pass_cnt++;
    chk_cnt++; if (r_spray !== 4) $display("FAIL basic_spray: got %0d want 4", r_spray); else pass_cnt++;
    chk_cnt++; if (r_soap + r_wax !== 0) $display("FAIL basic_soap_wax: got %0d want 0", r_soap + r_wax); else pass_cnt++;
    chk_cnt++; if (r_busy !== 4) $display("FAIL basic_busy: got %0d want 4", r_busy); else pass_cnt++;
    chk_cnt++; if (r_done !== 1 || r_done_idx !== 4) $display("FAIL basic_done: got %0d@%0d want 1@4", r_done, r_done_idx); else pass_cnt++;
    chk_cnt++; if (CREDITS !== 2'd0 || BUSY !== 1'b0) $display("FAIL basic_end: got credits %0d busy %b want 0 0", CREDITS, BUSY); else pass_cnt++;
  endtask

  task automatic test_deluxe();
    insert_token();
    insert_token();
    chk_cnt++; if (CREDITS !== 2'd2) $display("FAIL deluxe_credits: got %0d want 2", CREDITS); else pass_cnt++;
    press_start();
    run_wash(30, -1);
    chk_cnt++; if (r_spray !== 7) $display("FAIL deluxe_spray: got %0d want 7", r_spray); else pass_cnt++;
    chk_cnt++; if (r_soap !== 5) $display("FAIL deluxe_soap: got %0d want 5", r_soap); else pass_cnt++;
    chk_cnt++; if (r_wax !== 0) $display("FAIL deluxe_wax: got %0d want 0", r_wax); else pass_cnt++;
    chk_cnt++; if (r_busy + r_done !== 13) $display("FAIL deluxe_total: got %0d want 13", r_busy + r_done); else pass_cnt++;
    chk_cnt++; if (r_done_idx !== 12) $display("FAIL deluxe_done_idx: got %0d want 12", r_done_idx); else pass_cnt++;
  endtask

  task automatic test_premium_saturate();
    rej_seen = 0;
    for (int i = 0; i < 4; i++) insert_token();
    chk_cnt++; if (CREDITS !== 2'd3) $display("FAIL sat_credits: got %0d want 3", CREDITS); else pass_cnt++;
    chk_cnt++; if (rej_seen !== 1) $display("FAIL sat_rej: got %0d want 1", rej_seen); else pass_cnt++;
    press_start();
    run_wash(30, -1);
    chk_cnt++; if (r_wax !== 2) $display("FAIL premium_wax: got %0d want 2", r_wax); else pass_cnt++;
    chk_cnt++; if (r_busy !== 14) $display("FAIL premium_busy: got %0d want 14", r_busy); else pass_cnt++;
    chk_cnt++; if (r_done !== 1 || r_done_idx !== 14) $display("FAIL premium_done: got %0d@%0d want 1@14", r_done, r_done_idx); else pass_cnt++;
  endtask

  task automatic test_token_with_start();
    insert_token();
    TOKEN = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    run_wash(30, -1);
    chk_cnt++; if (r_soap !== 5 || r_done_idx !== 12) $display("FAIL tok_start_mode: got soap %0d done@%0d want 5 12", r_soap, r_done_idx); else pass_cnt++;
  endtask

  task automatic test_auto_start();
    insert_token();
    run_wash(40, -1);
    chk_cnt++; if (r_first_spray !== 19) $display("FAIL auto_first_spray: got %0d want 19", r_first_spray); else pass_cnt++;
    chk_cnt++; if (r_spray !== 4 || r_soap !== 0) $display("FAIL auto_program: got spray %0d soap %0d want 4 0", r_spray, r_soap); else pass_cnt++;
    chk_cnt++; if (r_done_idx !== 23) $display("FAIL auto_done_idx: got %0d want 23", r_done_idx); else pass_cnt++;
  endtask

  task automatic test_token_busy();
    insert_token();
    press_start();
    run_wash(20, 1);
    chk_cnt++; if (r_rej !== 1) $display("FAIL busy_rej: got %0d want 1", r_rej); else pass_cnt++;
    chk_cnt++; if (r_max_cred !== 0) $display("FAIL busy_credits: got %0d want 0", r_max_cred); else pass_cnt++;
    chk_cnt++; if (r_done_idx !== 4) $display("FAIL busy_done_idx: got %0d want 4", r_done_idx); else pass_cnt++;
    insert_token();
    press_start();
    run_wash(20, 4);
    chk_cnt++; if (r_rej !== 1 || r_max_cred !== 0) $display("FAIL done_token: got rej %0d cred %0d want 1 0", r_rej, r_max_cred); else pass_cnt++;
    chk_cnt++; if (CREDITS !== 2'd0 || BUSY !== 1'b0) $display("FAIL done_token_end: got credits %0d busy %b want 0 0", CREDITS, BUSY); else pass_cnt++;
  endtask

  task automatic test_abort();
    insert_token();
    insert_token();
    press_start();
    for (int i = 0; i < 5; i++) step();
    chk_cnt++; if (SOAP !== 1'b1) $display("FAIL abort_in_soap: got %b want 1", SOAP); else pass_cnt++;
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk_cnt++; if ({SPRAY, SOAP, WAX, BUSY, DONE} !== 5'b0) $display("FAIL abort_outputs: got %b want 00000", {SPRAY, SOAP, WAX, BUSY, DONE}); else pass_cnt++;
    run_wash(10, -1);
    chk_cnt++; if (r_done + r_spray + r_soap !== 0) $display("FAIL abort_quiet: got %0d want 0", r_done + r_spray + r_soap); else pass_cnt++;
    insert_token();
    insert_token();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk_cnt++; if (CREDITS !== 2'd0) $display("FAIL abort_credit_clear: got %0d want 0", CREDITS); else pass_cnt++;
    run_wash(25, -1);
    chk_cnt++; if (r_busy !== 0) $display("FAIL abort_no_autostart: got %0d want 0", r_busy); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    insert_token();
    press_start();
    step();
    chk_cnt++; if (SPRAY !== 1'b1) $display("FAIL arst_pre_spray: got %b want 1", SPRAY); else pass_cnt++;
    clr_n = 1'b0;
    #2;
    chk_cnt++; if ({SPRAY, SOAP, WAX, BUSY, DONE} !== 5'b0) $display("FAIL arst_outputs: got %b want 00000", {SPRAY, SOAP, WAX, BUSY, DONE}); else pass_cnt++;
    step();
    clr_n = 1'b1;
    run_wash(10, -1);
    chk_cnt++; if (r_busy + r_done !== 0) $display("FAIL arst_stays_idle: got %0d want 0", r_busy + r_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deluxe();
    test_premium_saturate();
    test_token_with_start();
    test_auto_start();
    test_token_busy();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
